// File: rtl/pipelined_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_subtractor
// Purpose  : Two's-complement add/subtract. The carry chain is split across
//            STAGES registered slices, with a valid/ready handshake.
// Options  : define ADDSUB_SATURATE_EN to clamp overflowed results.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder_subtractor #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int c_sw   = WIDTH / STAGES;
  localparam int c_last = STAGES - 1;
  localparam int c_msb  = WIDTH - 1;

  // Stage registers: valid, operand A, effective operand B, partial sum, slice carry
  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_c   [STAGES];

  // Values presented to each stage's register inputs
  logic             w_pv  [STAGES];
  logic [WIDTH-1:0] w_pa  [STAGES];
  logic [WIDTH-1:0] w_pb  [STAGES];
  logic [WIDTH-1:0] w_ps  [STAGES];
  logic             w_pc  [STAGES];
  logic [c_sw:0]    w_slice [STAGES];
  logic [WIDTH-1:0] w_nsum  [STAGES];
  logic [WIDTH-1:0] w_raw;

  assign in_ready = !rst && (out_ready || !out_valid);

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        // Subtraction is a + ~b + 1; the +1 enters as the first slice carry
        assign w_pv[k] = in_valid;
        assign w_pa[k] = a;
        assign w_pb[k] = mode ? ~b : b;
        assign w_ps[k] = '0;
        assign w_pc[k] = mode;
      end else begin : g_body
        assign w_pv[k] = r_vld[k-1];
        assign w_pa[k] = r_a[k-1];
        assign w_pb[k] = r_b[k-1];
        assign w_ps[k] = r_sum[k-1];
        assign w_pc[k] = r_c[k-1];
      end
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_slice[k] = {1'b0, w_pa[k][k*c_sw +: c_sw]}
                 + {1'b0, w_pb[k][k*c_sw +: c_sw]}
                 + {{c_sw{1'b0}}, w_pc[k]};
      w_nsum[k]  = w_ps[k];
      w_nsum[k][k*c_sw +: c_sw] = w_slice[k][c_sw-1:0];
    end
  end

  // Whole pipe moves only when in_ready; data is loaded only behind a valid bit
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
      end else if (in_ready) begin
        r_vld[k] <= w_pv[k];
        if (w_pv[k]) begin
          r_a[k]   <= w_pa[k];
          r_b[k]   <= w_pb[k];
          r_sum[k] <= w_nsum[k];
          r_c[k]   <= w_slice[k][c_sw];
        end
      end
    end
  end

  assign out_valid = r_vld[c_last];
  assign cout      = r_c[c_last];
  assign w_raw     = r_sum[c_last];
  assign overflow  = (r_a[c_last][c_msb] == r_b[c_last][c_msb]) &&
                     (w_raw[c_msb] != r_a[c_last][c_msb]);

`ifdef ADDSUB_SATURATE_EN
  assign result = !overflow          ? w_raw :
                  r_a[c_last][c_msb] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign result = w_raw;
`endif

endmodule
`default_nettype wire

// File: doc/pipelined_adder_subtractor.md
PIPELINED_ADDER_SUBTRACTOR -- requirements
Module: pipelined_adder_subtractor

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 4..64.
REQ-002 Parameter STAGES, default 2, number of register stages; 1..WIDTH; WIDTH % STAGES == 0 (each stage adds WIDTH/STAGES bits).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a/b/mode hold a valid request.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 a  input  WIDTH  signed operand A, two's complement.
REQ-008 b  input  WIDTH  signed operand B, two's complement.
REQ-009 mode  input  1  0 = a+b, 1 = a-b.
REQ-010 out_valid  output  1  result/cout/overflow hold a valid response.
REQ-011 out_ready  input  1  downstream accepts the response this cycle.
REQ-012 result  output  WIDTH  signed sum/difference.
REQ-013 cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-014 overflow  output  1  signed overflow of the operation.

Function
REQ-015 Arithmetic: b_eff = mode ? ~b : b; carry-in = mode; {cout, raw} = a + b_eff + mode, modulo 2^WIDTH.
REQ-016 overflow = (a[MSB] == b_eff[MSB]) && (raw[MSB] != a[MSB]).
REQ-017 Stage k (0..STAGES-1) computes slice bits [k*W/S +: W/S] using stage k-1's registered carry; higher operand slices and mode travel with the request, unused lower result slices are carried forward.
REQ-018 Request accepted when in_valid && in_ready; response appears on out_valid exactly STAGES cycles later if never stalled.
REQ-019 in_ready = !rst && (out_ready || !out_valid); combinational, no dependence on in_valid.
REQ-020 Pipeline advances (all stages shift one position) only in cycles where in_ready is 1; otherwise every stage register, including outputs, holds.
REQ-021 Each stage carries its own valid bit; bubbles propagate; an empty stage never asserts out_valid.
REQ-022 Response handed off when out_valid && out_ready; simultaneous hand-off and acceptance in same cycle is legal and sustains 1 request/cycle.
REQ-023 result/cout/overflow stable while out_valid && !out_ready; order of responses equals order of requests; no request dropped or duplicated.
REQ-024 a/b/mode values when in_valid=0 or in_ready=0 have no effect on any output.

Reset
REQ-025 While rst=1 at a rising edge: all stage valid bits, out_valid, result, cout, overflow SHALL become 0.
REQ-026 Reset mid-operation discards every in-flight request; first response after reset comes only from a request accepted after rst deasserts.
REQ-027 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro ADDSUB_SATURATE_EN: when defined, a response with overflow=1 SHALL carry result = 2^(WIDTH-1)-1 if a[MSB]=0, else -2^(WIDTH-1); overflow and cout still report the raw operation.
REQ-029 Without ADDSUB_SATURATE_EN, result SHALL be the wrapped raw value in all cases; latency and handshake identical in both builds.

Verification (WIDTH=16, STAGES=2)
REQ-030 a=0x7FFF, b=0x0001, mode=0 -> 2 cycles later result=0x8000, cout=0, overflow=1 (SAT build: result=0x7FFF).
REQ-031 a=0x0005, b=0x0007, mode=1 -> result=0xFFFE, cout=0, overflow=0; a=0x0007, b=0x0005, mode=1 -> result=0x0002, cout=1.
REQ-032 a=0x8000, b=0x0001, mode=1 -> result=0x7FFF, cout=1, overflow=1 (SAT build: result=0x8000).
REQ-033 10 back-to-back requests, out_ready=1 -> 10 responses on 10 consecutive cycles, in order, first at cycle 2.
REQ-034 Issue 3 requests, hold out_ready=0 for 4 cycles -> in_ready=0 once out_valid=1, first response held stable, release yields all 3 in order, none lost.
REQ-035 Assert rst for 1 cycle with 2 requests in flight -> out_valid=0 next cycle, neither stale response ever appears, in_ready=1 the cycle after rst drops.
